// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - op encodings presented on md_unit.op
//   - FSM state enum
//   - counter width helper: wide enough to hold XLEN+1
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIXUP
  } md_state_e;

  function automatic int cnt_width(input int xlen);
    return $clog2(xlen + 2);
  endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit
// per clock, XLEN iterations after a load.
//   clk, reset     : clock, async active-high reset
//   load           : capture dividend/divisor and start iterating
//   abort          : stop iterating and drop valid
//   dividend       : dividend magnitude
//   divisor        : divisor magnitude
//   quotient       : quotient (final once valid is high)
//   remainder      : remainder (final once valid is high)
//   valid          : high from the cycle after the last iteration until
//                    the next load/abort
// A zero divisor falls out naturally: every trial subtraction succeeds,
// giving an all-ones quotient and the dividend as remainder.
module md_divider
  import md_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = cnt_width(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            valid
);

  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;

  // quo_q doubles as the dividend shift register: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dsr_q};
    if (abort) begin
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      quo_d   = dividend;
      rem_d   = '0;
      dsr_d   = divisor;
      cnt_d   = CNT_W'(XLEN);
      valid_d = 1'b0;
    end else if (cnt_q != '0) begin
      // diff MSB set means the trial subtraction went negative: restore
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d   = cnt_q - 1'b1;
      valid_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign valid     = valid_q;

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
//   clk, reset : clock, async active-high reset
//   start, op  : op request from EX (MULT/MULTU/DIV/DIVU/MTHI/MTLO),
//                accepted only in IDLE with flush low
//   rs_val     : operand A / dividend / MTHI-MTLO source
//   rt_val     : operand B / divisor
//   flush      : abort the in-flight op, squash a same-cycle start
//   busy       : op in flight; hazard unit stalls MFHI/MFLO and md ops
//   done       : one-cycle pulse, new HI/LO visible this cycle
//   hi, lo     : HI/LO registers
// Timing from the start cycle: multiply done at +MUL_LAT, divide done at
// +XLEN+2 (XLEN iterations, one FIXUP cycle, then the committed result).
module md_unit
  import md_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = cnt_width(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic             done_q, done_d;

  // multiply path: operands come straight from the ports only when the
  // result must be committed at acceptance (MUL_LAT == 1)
  logic              in_idle;
  logic [XLEN-1:0]   mul_a, mul_b;
  logic              mul_sgn;
  logic [2*XLEN-1:0] mul_ext_a, mul_ext_b, product;

  assign in_idle   = (state_q == ST_IDLE);
  assign mul_a     = in_idle ? rs_val : a_q;
  assign mul_b     = in_idle ? rt_val : b_q;
  assign mul_sgn   = in_idle ? (op == MD_MULT) : (op_q == MD_MULT);
  // sign-extending to 2*XLEN makes the truncated product correct for both
  // signed and unsigned operands
  assign mul_ext_a = {{XLEN{mul_sgn & mul_a[XLEN-1]}}, mul_a};
  assign mul_ext_b = {{XLEN{mul_sgn & mul_b[XLEN-1]}}, mul_b};
  assign product   = mul_ext_a * mul_ext_b;

  // divide path: magnitudes are taken from the ports at acceptance
  logic            div_sgn_in;
  logic [XLEN-1:0] dvd_mag, dsr_mag;
  logic            div_load, div_abort, div_valid;
  logic [XLEN-1:0] div_quo, div_rem;
  logic            div_sgn_q, q_neg, r_neg;
  logic [XLEN-1:0] q_fix, r_fix;

  assign div_sgn_in = (op == MD_DIV);
  assign dvd_mag    = (div_sgn_in && rs_val[XLEN-1]) ? (~rs_val + 1'b1) : rs_val;
  assign dsr_mag    = (div_sgn_in && rt_val[XLEN-1]) ? (~rt_val + 1'b1) : rt_val;

  md_divider #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .abort     (div_abort),
    .dividend  (dvd_mag),
    .divisor   (dsr_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // quotient negative when signs differ, remainder follows the dividend;
  // MIN/-1 wraps back to MIN with remainder 0
  assign div_sgn_q = (op_q == MD_DIV);
  assign q_neg     = div_sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign r_neg     = div_sgn_q & a_q[XLEN-1];
  assign q_fix     = q_neg ? (~div_quo + 1'b1) : div_quo;
  assign r_fix     = r_neg ? (~div_rem + 1'b1) : div_rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div_load  = 1'b0;
    div_abort = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          op_d = op;
          a_d  = rs_val;
          b_d  = rt_val;
          case (op)
            MD_MULT, MD_MULTU: begin
              if (MUL_LAT == 1) begin
                {hi_d, lo_d} = product;
                done_d       = 1'b1;
              end else begin
                state_d = ST_MUL;
                cnt_d   = CNT_W'(MUL_LAT - 2);
              end
            end
            MD_DIV, MD_DIVU: begin
              div_load = 1'b1;
              state_d  = ST_DIV;
              cnt_d    = CNT_W'(XLEN - 1);
            end
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = product;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DIV: begin
        // the counter runs one behind the divider, so it reaches zero in
        // the last iteration cycle and FIXUP sees the final quotient
        if (flush) begin
          div_abort = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_FIXUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIXUP: begin
        if (flush) begin
          div_abort = 1'b1;
        end else if (div_valid) begin
          lo_d   = q_fix;
          hi_d   = r_fix;
          done_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_bad = 0;

  md_unit #(.XLEN(32), .MUL_LAT(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          bsy;
  } vec_t;

  vec_t vt[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one start in the current cycle, then wait (bounded) for done.
  // Returns with the bench sitting in the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bc);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    bc  = 0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bc;
    vt[0] = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 3, 2};
    vt[1] = '{MD_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 3, 2};
    vt[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33};
    vt[3] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 33};
    vt[4] = '{MD_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 34, 33};
    vt[5] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       34, 33};
    vt[6] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 34, 33};
    vt[7] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3, 2};
    vt[8] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3, 2};
    vt[9] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001, 34, 33};

    // reset state
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // table-driven ops; each new start lands in the previous done cycle
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, lat, bc);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d_busy", i), 64'(bc), 64'(vt[i].bsy));
      chk($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vt[i].hi});
      chk($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vt[i].lo});
    end

    // back-to-back: start in the done cycle is accepted
    run_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, lat, bc);
    chk("b2b_done_busy", {63'd0, busy}, 64'd0);
    op = MD_MULT; rs_val = 32'd6; rt_val = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_accepted", {63'd0, busy}, 64'd1);
    tick(); tick();
    chk("b2b_done", {63'd0, done}, 64'd1);
    chk("b2b_hi", {32'd0, hi}, 64'hFFFFFFFF);
    chk("b2b_lo", {32'd0, lo}, 64'hFFFFFFFA);
    // flush in the done cycle has no effect
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_done_hi", {32'd0, hi}, 64'hFFFFFFFF);
    chk("flush_done_lo", {32'd0, lo}, 64'hFFFFFFFA);
    chk("done_pulse", {63'd0, done}, 64'd0);

    // MTHI / MTLO
    op = MD_MTHI; rs_val = 32'd1; start = 1'b1;
    tick();
    chk("mthi_hi", {32'd0, hi}, 64'd1);
    chk("mthi_busy", {62'd0, busy, done}, 64'd0);
    op = MD_MTLO; rs_val = 32'd2;
    tick();
    start = 1'b0;
    chk("mtlo_lo", {32'd0, lo}, 64'd2);
    chk("mtlo_hi", {32'd0, hi}, 64'd1);

    // DIVU 100/7 with an ignored start while busy, flushed at cycle 10
    op = MD_DIVU; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = MD_MTHI; rs_val = 32'h55; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_ignored", {32'd0, hi}, 64'd1);
    for (int c = 3; c < 10; c++) tick();
    chk("pre_flush_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (done) seen++;
        tick();
      end
      chk("flush_no_done", 64'(seen), 64'd0);
    end
    chk("flush_hi", {32'd0, hi}, 64'd1);
    chk("flush_lo", {32'd0, lo}, 64'd2);

    // flush together with a start squashes it (MTHI and MULT)
    op = MD_MTHI; rs_val = 32'h22; start = 1'b1; flush = 1'b1;
    tick();
    chk("flush_mthi_hi", {32'd0, hi}, 64'd1);
    op = MD_MULT; rs_val = 32'd3; rt_val = 32'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_mult_busy", {63'd0, busy}, 64'd0);
    tick(); tick(); tick();
    chk("flush_mult_lo", {32'd0, lo}, 64'd2);

    // reset in the middle of a DIV
    op = MD_DIV; rs_val = 32'd50; rt_val = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    chk("mid_div_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_hi", {32'd0, hi}, 64'd0);
    chk("mid_rst_lo", {32'd0, lo}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    tick();
    reset = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (done || busy) seen++;
        tick();
      end
      chk("post_rst_quiet", 64'(seen), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
